vga_fb_arbiter: RTL and testbench

Shares one single-port frame-buffer RAM (14-bit address, 4-bit pixel) between two requesters: the VGA scanout reader, and the Nios pixel-write PIO path (pxl_addr/pxl_data plus a toggle strobe).
- Pixel writes are buffered in a small FIFO.
- Scanout reads always win.
- A hardware clear sequencer fills the whole buffer with a colour on command.
- Sits between the Nios system outputs and the frame-buffer RAM.

---
 rtl/vga_fb_pkg.sv | 17 +
 rtl/vga_fb_wr_fifo.sv | 64 ++++++
 rtl/vga_fb_arbiter.sv | 129 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter.
package vga_fb_pkg;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 4;
  localparam int FB_PIXELS  = 16384;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/vga_fb_wr_fifo.sv
// Pending pixel-write FIFO; when full it still takes an entry
// if the head leaves in the same cycle.
module vga_fb_wr_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enq,
  input  wr_entry_t              enq_data,
  input  logic                   deq,
  output wr_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  wr_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          enq_ok, deq_ok;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];
  assign deq_ok = deq && !empty;
  assign enq_ok = enq && (!full || deq_ok);
  assign drop   = enq && !enq_ok;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (deq_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (enq_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    unique case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[wr_ptr_q] <= enq_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads, buffered Nios
// pixel writes and a full-buffer clear sequencer.
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_toggle,
  output logic              wr_busy,
  output logic              wr_overflow,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] FB_LIM  = (ADDR_W+1)'(FB_PIXELS);
  localparam logic [ADDR_W:0] FB_LAST = (ADDR_W+1)'(FB_PIXELS - 1);

  logic              armed_q, prev_tgl_q, ovf_q;
  logic              ovf_d;
  fb_state_t         state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_p1_q, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              fifo_enq, fifo_deq;
  logic              fifo_full, fifo_empty, fifo_drop;
  wr_entry_t         fifo_head;
  logic [CW:0]       fifo_count;

  // The first cycle after reset only loads the toggle reference.
  assign fifo_enq = armed_q && (wr_toggle != prev_tgl_q);
  assign ovf_d    = ovf_q || fifo_drop;

  vga_fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .enq      (fifo_enq),
    .enq_data ('{addr: wr_addr, data: wr_data}),
    .deq      (fifo_deq),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .drop     (fifo_drop)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we      = 1'b0;
    fifo_deq    = 1'b0;
    if (rd_req) begin
      mem_addr_d = rd_addr;
    end else if (state_q == CLEAR) begin
      mem_addr_d  = clr_cnt_q[ADDR_W-1:0];
      mem_wdata_d = clr_color_q;
      mem_we      = 1'b1;
      clr_cnt_d   = clr_cnt_q + 1'b1;
      if (clr_cnt_q == FB_LAST) state_d = IDLE;
    end else if (!fifo_empty) begin
      fifo_deq    = 1'b1;
      mem_addr_d  = fifo_head.addr;
      mem_wdata_d = fifo_head.data;
      mem_we      = ({1'b0, fifo_head.addr} < FB_LIM);
    end
    if (state_q == IDLE && clear_start) begin
      state_d     = CLEAR;
      clr_cnt_d   = '0;
      clr_color_d = clear_color;
    end
  end

  assign rd_data_d = rd_p1_q ? mem_rdata : rd_data_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      armed_q     <= 1'b0;
      prev_tgl_q  <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_p1_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      armed_q     <= 1'b1;
      prev_tgl_q  <= wr_toggle;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_p1_q     <= rd_req;
      rd_valid_q  <= rd_p1_q;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wr_busy     = fifo_full;
  assign wr_overflow = ovf_q;
  assign clear_busy  = (state_q == CLEAR);
  assign mem_addr    = mem_addr_d;
  assign mem_wdata   = mem_wdata_d;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed sequences, a vector table and
// randomized traffic against a queue-based reference model.
module tb_vga_fb_arbiter;
  localparam int FD = 4;
  localparam int FB = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] wr_addr, rd_addr, mem_addr;
  logic [3:0]  wr_data, rd_data, clear_color, mem_wdata;
  logic [3:0]  mem_rdata = 4'h0;
  logic        wr_toggle, wr_busy, wr_overflow;
  logic        rd_req, rd_valid, clear_start, clear_busy, mem_we;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_toggle     (wr_toggle),
    .wr_busy       (wr_busy),
    .wr_overflow   (wr_overflow),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .clear_start   (clear_start),
    .clear_color   (clear_color),
    .clear_busy    (clear_busy),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Physical RAM seen by the DUT and the model's own copy.
  logic [3:0] pram [FB];
  logic [3:0] mram [FB];

  always @(posedge clk) begin
    mem_rdata <= pram[mem_addr];
    if (mem_we) pram[mem_addr] = mem_wdata;
  end

  typedef struct {
    logic [13:0] a;
    logic [3:0]  d;
  } went_t;
  typedef struct {
    int         due;
    logic [3:0] d;
  } rdexp_t;

  went_t       pend [$];
  rdexp_t      exp_rd [$];
  bit          m_armed, m_prev, m_clr, m_ovf;
  int          m_cnt;
  logic [3:0]  m_color;
  logic [13:0] last_addr;
  int          cyc = 0;
  int          we_cnt = 0;
  int          rv_cnt = 0;

  function automatic void model_reset();
    pend.delete();
    exp_rd.delete();
    m_armed = 0;
    m_prev = 0;
    m_clr = 0;
    m_ovf = 0;
    m_cnt = 0;
    last_addr = '0;
  endfunction

  // Reference model: one step per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    logic       e_we, was_clr, exp_v;
    logic [3:0] e_wd;
    went_t      e;
    if (mem_we) we_cnt++;
    if (rd_valid) rv_cnt++;
    if (!rst_n) begin
      model_reset();
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_wr_busy", wr_busy, 0);
      chk("rst_wr_overflow", wr_overflow, 0);
    end else begin
      exp_v = exp_rd.size() > 0 && exp_rd[0].due == cyc;
      chk("rd_valid", rd_valid, exp_v);
      if (exp_v) begin
        chk("rd_data", rd_data, exp_rd[0].d);
        void'(exp_rd.pop_front());
      end
      chk("clear_busy", clear_busy, m_clr);
      chk("wr_busy", wr_busy, pend.size() == FD);
      chk("wr_overflow", wr_overflow, m_ovf);
      e_we = 0;
      e_wd = '0;
      was_clr = m_clr;
      if (rd_req) begin
        last_addr = rd_addr;
        exp_rd.push_back('{cyc + 2, mram[rd_addr]});
      end else if (m_clr) begin
        e_we = 1;
        last_addr = 14'(m_cnt);
        e_wd = m_color;
        m_cnt++;
        if (m_cnt == FB) m_clr = 0;
      end else if (pend.size() > 0) begin
        e = pend.pop_front();
        last_addr = e.a;
        e_we = (int'(e.a) < FB);
        e_wd = e.d;
      end
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, last_addr);
      if (e_we) begin
        chk("mem_wdata", mem_wdata, e_wd);
        mram[last_addr] = e_wd;
      end
      if (!was_clr && clear_start) begin
        m_clr = 1;
        m_cnt = 0;
        m_color = clear_color;
      end
      if (!m_armed) m_armed = 1;
      else if (wr_toggle != m_prev) begin
        if (pend.size() < FD) pend.push_back('{wr_addr, wr_data});
        else m_ovf = 1;
      end
      m_prev = wr_toggle;
    end
    cyc++;
  end

  typedef struct {
    bit          tg;
    logic [13:0] wa;
    logic [3:0]  wd;
    bit          rq;
    logic [13:0] ra;
    bit          we;
    logic [13:0] ma;
    logic [3:0]  md;
    bit          busy;
    bit          ovf;
  } vec_t;
  vec_t tab [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(int rdiv);
    rd_req  = ($urandom_range(0, rdiv - 1) == 0);
    rd_addr = 14'($urandom);
    wr_addr = 14'($urandom);
    wr_data = 4'($urandom);
    if ($urandom_range(0, 2) == 0) wr_toggle = ~wr_toggle;
  endtask

  initial begin
    int we0, rv0, ok;
    bit found;
    tab[0]  = '{1, 14'h10, 4'h1, 1, 14'h100, 0, 14'h100, 4'h0, 0, 0};
    tab[1]  = '{1, 14'h11, 4'h2, 1, 14'h101, 0, 14'h101, 4'h0, 0, 0};
    tab[2]  = '{1, 14'h12, 4'h3, 1, 14'h102, 0, 14'h102, 4'h0, 0, 0};
    tab[3]  = '{1, 14'h13, 4'h4, 1, 14'h103, 0, 14'h103, 4'h0, 0, 0};
    tab[4]  = '{1, 14'h14, 4'h5, 1, 14'h104, 0, 14'h104, 4'h0, 1, 0};
    tab[5]  = '{0, 14'h0, 4'h0, 1, 14'h105, 0, 14'h105, 4'h0, 1, 1};
    tab[6]  = '{0, 14'h0, 4'h0, 0, 14'h0, 1, 14'h10, 4'h1, 1, 1};
    tab[7]  = '{0, 14'h0, 4'h0, 0, 14'h0, 1, 14'h11, 4'h2, 0, 1};
    tab[8]  = '{0, 14'h0, 4'h0, 0, 14'h0, 1, 14'h12, 4'h3, 0, 1};
    tab[9]  = '{0, 14'h0, 4'h0, 0, 14'h0, 1, 14'h13, 4'h4, 0, 1};
    tab[10] = '{0, 14'h0, 4'h0, 0, 14'h0, 0, 14'h13, 4'h0, 0, 1};

    for (int i = 0; i < FB; i++) begin
      pram[i] = 4'($urandom);
      mram[i] = pram[i];
    end
    model_reset();
    rst_n = 0;
    wr_toggle = 1;
    wr_addr = '0;
    wr_data = '0;
    rd_req = 0;
    rd_addr = '0;
    clear_start = 0;
    clear_color = '0;

    // Toggle held high through reset: no write after release.
    repeat (3) tick();
    rst_n = 1;
    we0 = we_cnt;
    repeat (20) tick();
    #1;
    chk("t1_no_write", we_cnt - we0, 0);
    chk("t1_overflow", wr_overflow, 0);

    // Single write issues the cycle after the toggle.
    tick();
    wr_addr = 14'h0123;
    wr_data = 4'hA;
    wr_toggle = ~wr_toggle;
    tick();
    #1;
    chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 14'h0123);
    chk("t2_wdata", mem_wdata, 4'hA);
    tick();
    #1;
    chk("t2_empty_after", mem_we, 0);

    // Reads hold off two queued writes.
    tick();
    wr_addr = 14'h0200;
    wr_data = 4'h1;
    wr_toggle = ~wr_toggle;
    tick();
    wr_addr = 14'h0201;
    wr_data = 4'h2;
    wr_toggle = ~wr_toggle;
    rd_req = 1;
    rd_addr = 14'd0;
    we0 = we_cnt;
    rv0 = rv_cnt;
    for (int i = 1; i < 10; i++) begin
      tick();
      rd_addr = 14'(i);
    end
    tick();
    rd_req = 0;
    #1;
    chk("t3_reads_no_write", we_cnt - we0, 0);
    chk("t3_w0_we", mem_we, 1);
    chk("t3_w0_addr", mem_addr, 14'h0200);
    tick();
    #1;
    chk("t3_w1_we", mem_we, 1);
    chk("t3_w1_addr", mem_addr, 14'h0201);
    tick();
    #1;
    chk("t3_rd_count", rv_cnt - rv0, 10);

    // Fill under read pressure, overflow, then drain in order.
    for (int r = 0; r < 11; r++) begin
      tick();
      if (tab[r].tg) wr_toggle = ~wr_toggle;
      wr_addr = tab[r].wa;
      wr_data = tab[r].wd;
      rd_req = tab[r].rq;
      rd_addr = tab[r].ra;
      #1;
      chk($sformatf("t4_we_%0d", r), mem_we, tab[r].we);
      chk($sformatf("t4_addr_%0d", r), mem_addr, tab[r].ma);
      if (tab[r].we)
        chk($sformatf("t4_wdata_%0d", r), mem_wdata, tab[r].md);
      chk($sformatf("t4_busy_%0d", r), wr_busy, tab[r].busy);
      chk($sformatf("t4_ovf_%0d", r), wr_overflow, tab[r].ovf);
    end

    // Clear with a write queued in the same cycle.
    tick();
    clear_color = 4'h3;
    clear_start = 1;
    wr_addr = 14'h0005;
    wr_data = 4'h7;
    wr_toggle = ~wr_toggle;
    tick();
    clear_start = 0;
    ok = 0;
    for (int i = 0; i < FB; i++) begin
      #1;
      if (mem_we && mem_addr == 14'(i) && mem_wdata == 4'h3 && clear_busy)
        ok++;
      tick();
    end
    #1;
    chk("t5_clear_writes", ok, FB);
    chk("t5_post_we", mem_we, 1);
    chk("t5_post_addr", mem_addr, 14'h0005);
    chk("t5_post_wdata", mem_wdata, 4'h7);
    chk("t5_post_busy", clear_busy, 0);

    // Asynchronous reset in the middle of a clear.
    tick();
    clear_color = 4'h9;
    clear_start = 1;
    tick();
    clear_start = 0;
    wr_addr = 14'h0007;
    wr_data = 4'h1;
    wr_toggle = ~wr_toggle;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (mem_we && mem_addr == 14'd98) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t6_reach_98", found, 1);
    tick();
    rd_req = 1;
    rd_addr = 14'd3;
    tick();
    rd_req = 0;
    tick();
    chk("t6_pre_we", mem_we, 1);
    chk("t6_pre_addr", mem_addr, 14'd100);
    chk("t6_pre_rv", rd_valid, 1);
    rst_n = 0;
    #1;
    chk("t6_async_we", mem_we, 0);
    chk("t6_async_busy", clear_busy, 0);
    chk("t6_async_rv", rd_valid, 0);
    tick();
    tick();
    rst_n = 1;
    we0 = we_cnt;
    repeat (10) tick();
    #1;
    chk("t6_fifo_empty", we_cnt - we0, 0);
    chk("t6_idle", clear_busy, 0);
    chk("t6_not_busy", wr_busy, 0);

    // Random traffic, then a clear under random load.
    repeat (2000) begin
      tick();
      rand_inputs(2);
    end
    tick();
    rand_inputs(4);
    clear_color = 4'($urandom);
    clear_start = 1;
    tick();
    clear_start = 0;
    rand_inputs(4);
    for (int i = 0; i < 40000 && m_clr; i++) begin
      tick();
      rand_inputs(4);
    end
    chk("rand_clear_done", clear_busy, 0);
    repeat (500) begin
      tick();
      rand_inputs(2);
    end
    tick();
    rd_req = 0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
